// File: rtl/ram_bist_initiator.sv
// Write/read-back self-test sequencer driving a single-port bigRam.
// Define INVERT_PASS_EN to add a second pass using the inverted pattern.
module ram_bist_initiator #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Lo,
    input  logic [ADDR_W-1:0] Hi,
    input  logic [DATA_W-1:0] Seed,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Din,
    output logic              WR,
    output logic              en,
    input  logic [DATA_W-1:0] Dout,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [ADDR_W-1:0] FailAddr,
    output logic [ERR_W-1:0]  ErrCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [2:0] DRN_LAST = 3'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] lo_q, lo_d;
    logic [ADDR_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              wr_q, wr_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] fail_q, fail_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [2:0]        drain_q, drain_d;
    logic              pv_q [RD_LAT];
    logic              pv_d [RD_LAT];
    logic [ADDR_W-1:0] pa_q [RD_LAT];
    logic [ADDR_W-1:0] pa_d [RD_LAT];
    logic              inv_w;
    logic              mis;

`ifdef INVERT_PASS_EN
    logic inv_q, inv_d;
    assign inv_w = inv_q;
`else
    assign inv_w = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] pat(
        input logic [DATA_W-1:0] s,
        input logic [ADDR_W-1:0] a,
        input logic              inv
    );
        return s ^ DATA_W'(a) ^ {DATA_W{inv}};
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            seed_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
            err_q   <= '0;
            drain_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pa_q[i] <= '0;
            end
`ifdef INVERT_PASS_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            seed_q  <= seed_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            drain_q <= drain_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= pv_d[i];
                pa_q[i] <= pa_d[i];
            end
`ifdef INVERT_PASS_EN
            inv_q   <= inv_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        seed_d  = seed_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wr_d    = wr_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        err_d   = err_q;
        drain_d = drain_q;
`ifdef INVERT_PASS_EN
        inv_d   = inv_q;
`endif

        // Expected address follows each issued read through the RAM latency
        pv_d[0] = en_q & ~wr_q;
        pa_d[0] = addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
        end

        mis = pv_q[RD_LAT-1] &&
              (Dout != pat(seed_q, pa_q[RD_LAT-1], inv_w));
        if (mis) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) fail_d = pa_q[RD_LAT-1];
        end

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    lo_d   = Lo;
                    hi_d   = Hi;
                    seed_d = Seed;
                    pass_d = 1'b0;
                    fail_d = '0;
                    err_d  = '0;
`ifdef INVERT_PASS_EN
                    inv_d  = 1'b0;
`endif
                    if (Hi < Lo) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                        busy_d  = 1'b1;
                        en_d    = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = Lo;
                        din_d   = pat(Seed, Lo, 1'b0);
                    end
                end
            end
            S_WRITE: begin
                if (addr_q == hi_q) begin
                    state_d = S_READ;
                    wr_d    = 1'b0;
                    addr_d  = lo_q;
                    din_d   = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                    din_d  = pat(seed_q, addr_q + 1'b1, inv_w);
                end
            end
            S_READ: begin
                if (addr_q == hi_q) begin
                    state_d = S_DRAIN;
                    en_d    = 1'b0;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRN_LAST) begin
`ifdef INVERT_PASS_EN
                    if (!inv_q) begin
                        state_d = S_WRITE;
                        inv_d   = 1'b1;
                        en_d    = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = lo_q;
                        din_d   = pat(seed_q, lo_q, 1'b1);
                    end else
`endif
                    begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_d == '0);
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Address  = addr_q;
    assign Din      = din_q;
    assign WR       = wr_q;
    assign en       = en_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Pass     = pass_q;
    assign FailAddr = fail_q;
    assign ErrCount = err_q;

endmodule

// File: tb/tb_ram_bist_initiator.sv
// Directed bench for ram_bist_initiator with a behavioural bigRam model.
// Expected values follow INVERT_PASS_EN when the build defines it.
module tb_ram_bist_initiator;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [7:0]  Lo, Hi;
    logic [31:0] Seed;
    logic [7:0]  Address;
    logic [31:0] Din;
    logic        WR, en;
    logic [31:0] Dout;
    logic        Busy, Done, Pass;
    logic [7:0]  FailAddr;
    logic [15:0] ErrCount;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [256];
    logic [31:0] rdata = '0;
    logic [7:0]  raddr = '0;
    logic        fault_on = 1'b0;
    logic [7:0]  fault_addr = '0;

    int dcyc, encnt, dcnt, wrcnt;
    logic        c1_wr, c1_en, c2_en, c2_wr, c1_busy;
    logic [7:0]  c1_addr, c2_addr;
    logic [31:0] c1_din;

    ram_bist_initiator dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
        .Lo(Lo), .Hi(Hi), .Seed(Seed),
        .Address(Address), .Din(Din), .WR(WR), .en(en),
        .Dout(Dout), .Busy(Busy), .Done(Done), .Pass(Pass),
        .FailAddr(FailAddr), .ErrCount(ErrCount)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (en) begin
            if (WR) mem[Address] <= Din;
            else begin
                rdata <= mem[Address];
                raddr <= Address;
            end
        end
    end

    assign Dout = rdata ^ {31'b0, fault_on && (raddr == fault_addr)};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_done(input int n);
`ifdef INVERT_PASS_EN
        return 4 * n + 2 + 1;
`else
        return 2 * n + 1 + 1;
`endif
    endfunction

    function automatic int exp_en(input int n);
`ifdef INVERT_PASS_EN
        return 4 * n;
`else
        return 2 * n;
`endif
    endfunction

    // Cycle 0 is the cycle Start is high; sampling happens on negedges.
    task automatic run(input logic [7:0] lo, input logic [7:0] hi,
                       input logic [31:0] seed, input int s2,
                       input int rst_at, input int fault_from);
        @(negedge Clk);
        Lo = lo; Hi = hi; Seed = seed; Start = 1'b1;
        fault_on = (fault_from == 0);
        dcyc = -1; encnt = 0; dcnt = 0; wrcnt = 0;
        for (int c = 1; c <= 1200; c++) begin
            @(negedge Clk);
            Start = (c == s2);
            fault_on = (c >= fault_from);
            if (c == rst_at) begin
                Reset_n = 1'b0;
                break;
            end
            if (c == 1) begin
                c1_wr = WR; c1_en = en; c1_addr = Address;
                c1_din = Din; c1_busy = Busy;
            end
            if (c == 2) begin
                c2_en = en; c2_wr = WR; c2_addr = Address;
            end
            if (en) encnt++;
            if (en && WR) wrcnt++;
            if (Done) begin
                dcnt++;
                if (dcyc < 0) dcyc = c;
            end
            if (dcyc >= 0 && c > dcyc + 3) break;
        end
        Start = 1'b0;
        fault_on = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0;
        Lo = '0; Hi = '0; Seed = '0;
        repeat (2) @(negedge Clk);
        chk("rst_addr", Address, 0);
        chk("rst_din", Din, 0);
        chk("rst_wr", WR, 0);
        chk("rst_en", en, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_pass", Pass, 0);
        chk("rst_fail", FailAddr, 0);
        chk("rst_err", ErrCount, 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Single address
        run(8'h29, 8'h29, 32'h729FB2B2, 0, 0, 100000);
        chk("one_c1_en", c1_en, 1);
        chk("one_c1_wr", c1_wr, 1);
        chk("one_c1_addr", c1_addr, 8'h29);
        chk("one_c1_din", c1_din, 32'h729FB29B);
        chk("one_c1_busy", c1_busy, 1);
        chk("one_c2_en", c2_en, 1);
        chk("one_c2_wr", c2_wr, 0);
        chk("one_c2_addr", c2_addr, 8'h29);
        chk("one_done_cyc", dcyc, exp_done(1));
        chk("one_pass", Pass, 1);
        chk("one_err", ErrCount, 0);

        // Full range
        run(8'h00, 8'hFF, 32'h47FF082B, 0, 0, 100000);
        chk("full_done_cyc", dcyc, exp_done(256));
        chk("full_en_cycles", encnt, exp_en(256));
        chk("full_wr_cycles", wrcnt, exp_en(256) / 2);
        chk("full_pass", Pass, 1);
        chk("full_err", ErrCount, 0);

        // Fault on bit 0 of the word read back from 0x6F
        fault_addr = 8'h6F;
        run(8'h00, 8'hFF, 32'h13572468, 0, 0, 0);
        chk("flt_pass", Pass, 0);
        chk("flt_failaddr", FailAddr, 8'h6F);
`ifdef INVERT_PASS_EN
        chk("flt_err", ErrCount, 2);
`else
        chk("flt_err", ErrCount, 1);
`endif

        // Empty window
        run(8'hAA, 8'h10, 32'hDEADBEEF, 0, 0, 100000);
        chk("empty_done_cyc", dcyc, 1);
        chk("empty_en", encnt, 0);
        chk("empty_pass", Pass, 1);
        chk("empty_err", ErrCount, 0);
        chk("empty_fail", FailAddr, 0);

        // Second Start while busy
        run(8'h10, 8'h1F, 32'h0F0F0F0F, 5, 0, 100000);
        chk("busy_done_cnt", dcnt, 1);
        chk("busy_done_cyc", dcyc, exp_done(16));
        chk("busy_pass", Pass, 1);

        // Reset during write
        run(8'h00, 8'hFF, 32'h55AA55AA, 0, 50, 100000);
        #1;
        chk("mid_rst_en", en, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_err", ErrCount, 0);
        chk("mid_rst_addr", Address, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        run(8'h20, 8'h23, 32'hCAFEF00D, 0, 0, 100000);
        chk("post_rst_done_cyc", dcyc, exp_done(4));
        chk("post_rst_pass", Pass, 1);

`ifdef INVERT_PASS_EN
        // Fault on 0x02 in the inverted pass only
        fault_addr = 8'h02;
        run(8'h00, 8'h03, 32'h89ABCDEF, 0, 0, 12);
        chk("inv_done_cyc", dcyc, 19);
        chk("inv_pass", Pass, 0);
        chk("inv_failaddr", FailAddr, 8'h02);
        chk("inv_err", ErrCount, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_bist_initiator.md
Name: ram_bist_initiator

Overview:
- Bus initiator and self-test sequencer for the single-port bigRam interface (Address, Din, Dout, WR, en, shared Clk).
- On Start, writes a deterministic pattern across an address window, reads the window back, and compares each returned word.
- Reports pass/fail, the first failing address and an error count.
- Sits between the control logic and a bigRam instance, so RAM bring-up runs in hardware rather than from a bench.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 32, RAM data width.
- RD_LAT, 1, cycles from read address/en presented to Dout valid (1..4).
- ERR_W, 16, error counter width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- Lo  in  ADDR_W  first address of window, inclusive; sampled with Start.
- Hi  in  ADDR_W  last address of window, inclusive; sampled with Start.
- Seed  in  DATA_W  pattern seed; sampled with Start.
- Address  out  ADDR_W  RAM address.
- Din  out  DATA_W  RAM write data.
- WR  out  1  RAM write (1) / read (0) select.
- en  out  1  RAM enable.
- Dout  in  DATA_W  RAM read data.
- Busy  out  1  high from the cycle after Start until Done.
- Done  out  1  one-cycle completion pulse.
- Pass  out  1  result, valid from Done until the next Start.
- FailAddr  out  ADDR_W  first miscomparing address; 0 if none.
- ErrCount  out  ERR_W  number of miscompares, saturating at all-ones.

Behaviour:
- Reset values: Address=0, Din=0, WR=0, en=0, Busy=0, Done=0, Pass=0, FailAddr=0, ErrCount=0, state=IDLE.
- Reset asserted mid-operation: all outputs and the state return to reset values immediately (en drops asynchronously). No partial result is kept.
- Pattern: P(a) = Seed XOR zero-extend(a) to DATA_W.
- States: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On Start=1, latch Lo, Hi and Seed; clear Pass, FailAddr and ErrCount; go to WRITE.
  - If Hi < Lo, go directly to DONE with Pass=1 and ErrCount=0. No RAM access occurs.
- WRITE: one write per cycle with en=1, WR=1, Address=a, Din=P(a), for a = Lo..Hi. Go to READ after Address==Hi.
- READ: one read per cycle with en=1, WR=0, Address=a, Din=0, for a = Lo..Hi. Go to DRAIN after Address==Hi.
- Read pipeline: expected address is carried in an RD_LAT-deep shift register. Dout is compared to P(expected address) RD_LAT cycles after issue.
- DRAIN: en=0 for RD_LAT cycles while the outstanding compares complete.
- DONE: Done=1 for one cycle, Busy=0 in the same cycle; then return to IDLE.
- Timing: Start sampled in cycle 0; first write in cycle 1. With N = Hi-Lo+1, Done is asserted in cycle 2N+RD_LAT+1.
- Miscompare handling:
  - ErrCount increments, saturating at all-ones.
  - The first miscompare latches FailAddr; later errors do not change it.
  - Pass = (ErrCount==0), registered at Done.
- Wrap: the address counter terminates on equality with Hi and never increments past it. Hi = all-ones must not wrap to 0.
- Start outside IDLE is ignored. Start coincident with Done is ignored.
- en=0 in IDLE, DRAIN and DONE. Address holds its last value when en=0.

Optional Feature:
- Macro INVERT_PASS_EN.
- Defined: after DRAIN, run a second WRITE/READ/DRAIN pass with pattern ~P(a). FailAddr records the first error across both passes. Done is asserted in cycle 4N+2*RD_LAT+1.
- Undefined: single pass only; no second-pass logic is synthesized.

Test Plan:
- Single address: Lo=Hi=0x29, Seed=0x729FB2B2, bigRam model, RD_LAT=1.
  -> Cycle 1: WR=1, Address=0x29, Din=0x729FB29B.
  -> Cycle 2: read of 0x29.
  -> Done in cycle 4, Pass=1, ErrCount=0.
- Full range: Lo=0x00, Hi=0xFF, Seed=0x47FF082B.
  -> Address never exceeds 0xFF or wraps.
  -> Done in cycle 514, Pass=1.
- Fault injection: bench XORs bit 0 of Dout when 0x6F is read back, window 0x00..0xFF.
  -> Pass=0, FailAddr=0x6F, ErrCount=1.
- Empty window and Start while Busy:
  - Lo=0xAA, Hi=0x10 -> Done in cycle 1, Pass=1, en never asserted.
  - Second Start pulse during WRITE -> ignored; Done occurs exactly once.
- Reset mid-write: Reset_n low at cycle 50 of a 0x00..0xFF run.
  -> en=0, Busy=0, ErrCount=0 immediately.
  -> A subsequent Start completes normally.
- With INVERT_PASS_EN, window 0x00..0x03, fault injected at 0x02 in the second pass only.
  -> Done in cycle 19, Pass=0, FailAddr=0x02, ErrCount=1.
